// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter and its shift datapath.
//   - operation encodings carried on reqN_op
//   - arbiter FSM state encodings
//   - latched request record (op, operand, amount)
package shift_arbiter_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    SHOP_SLL  = 2'b00,
    SHOP_SRL  = 2'b01,
    SHOP_SRA  = 2'b10,
    SHOP_PASS = 2'b11
  } shop_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

  typedef struct packed {
    shop_e               op;
    logic [DATA_W-1:0]   data;
    logic [SHAMT_W-1:0]  amt;
  } shift_req_t;

endpackage

// File: rtl/shift_arbiter_core.sv
// shift_core: purely combinational 32-bit barrel shifter.
// Ports:
//   data   in  DATA_W   operand
//   amt    in  SHAMT_W  shift amount (all bits used, no overflow)
//   op     in  2        SHOP_SLL / SHOP_SRL / SHOP_SRA / SHOP_PASS
//   result out DATA_W   shifted operand
// Left and right shifters are log-depth stage chains: stage gi shifts by
// 2**gi when amt[gi] is set. The right chain shares one fill bit that is
// data[MSB] for sra and 0 for srl.
module shift_core
  import shift_arbiter_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] amt,
  input  logic [1:0]         op,
  output logic [DATA_W-1:0]  result
);

  logic [DATA_W-1:0] sl_stage [SHAMT_W+1];
  logic [DATA_W-1:0] sr_stage [SHAMT_W+1];
  logic              fill;

  assign fill        = (shop_e'(op) == SHOP_SRA) & data[DATA_W-1];
  assign sl_stage[0] = data;
  assign sr_stage[0] = data;

  generate
    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      localparam int STEP = 1 << gi;
      // sl_logical stage
      assign sl_stage[gi+1] = amt[gi] ? {sl_stage[gi][DATA_W-STEP-1:0], {STEP{1'b0}}}
                                      : sl_stage[gi];
      // shared srl/sra stage
      assign sr_stage[gi+1] = amt[gi] ? {{STEP{fill}}, sr_stage[gi][DATA_W-1:STEP]}
                                      : sr_stage[gi];
    end
  endgenerate

  always_comb begin
    result = data;
    case (shop_e'(op))
      SHOP_SLL:  result = sl_stage[SHAMT_W];
      SHOP_SRL:  result = sr_stage[SHAMT_W];
      SHOP_SRA:  result = sr_stage[SHAMT_W];
      SHOP_PASS: result = data;
      default:   result = data;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter sharing one barrel shifter between
// the CPU ALU (requester 0) and the move generator (requester 1).
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   reqN_valid/ready             request handshake (ready is combinational)
//   reqN_op/data/amt             request payload
//   rspN_valid/ready/data        response handshake, data 0 when not valid
//   busy                         FSM not in IDLE
// One operation is in flight at a time: IDLE accepts, SHIFT computes and
// registers the result, RESP holds it until the owner takes it.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [1:0]         req0_op,
  input  logic [DATA_W-1:0]  req0_data,
  input  logic [SHAMT_W-1:0] req0_amt,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [DATA_W-1:0]  rsp0_data,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [1:0]         req1_op,
  input  logic [DATA_W-1:0]  req1_data,
  input  logic [SHAMT_W-1:0] req1_amt,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [DATA_W-1:0]  rsp1_data,
  output logic               busy
);

  state_e            state_reg, state_next;
  logic              last_grant_reg;
  logic              owner_reg;
  logic [1:0]        op_reg;
  logic [DATA_W-1:0] data_reg;
  logic [SHAMT_W-1:0] amt_reg;
  logic [DATA_W-1:0] result_reg;
  logic [DATA_W-1:0] result_next;

  logic grant;
  logic accept;
  logic rsp_fire;

  shift_core #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .data   (data_reg),
    .amt    (amt_reg),
    .op     (op_reg),
    .result (result_next)
  );

  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    accept     = 1'b0;
    rsp_fire   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_data  = '0;
    rsp1_data  = '0;
    busy       = (state_reg != ST_IDLE);

    case (state_reg)
      ST_IDLE: begin
        // Single requester wins outright; a tie goes to whoever did not
        // win last time.
        if (req0_valid && !req1_valid)      grant = 1'b0;
        else if (!req0_valid && req1_valid) grant = 1'b1;
        else                                grant = ~last_grant_reg;
        // Reset masks ready so no handshake is reported during reset.
        accept     = (req0_valid | req1_valid) & ~reset;
        req0_ready = accept & ~grant;
        req1_ready = accept & grant;
        if (accept) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (owner_reg) begin
          rsp1_valid = 1'b1;
          rsp1_data  = result_reg;
          rsp_fire   = rsp1_ready;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_data  = result_reg;
          rsp_fire   = rsp0_ready;
        end
        if (rsp_fire) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      op_reg         <= '0;
      data_reg       <= '0;
      amt_reg        <= '0;
      result_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        owner_reg <= grant;
        op_reg    <= grant ? req1_op   : req0_op;
        data_reg  <= grant ? req1_data : req0_data;
        amt_reg   <= grant ? req1_amt  : req0_amt;
      end
      if (state_reg == ST_SHIFT) result_reg <= result_next;
      if (rsp_fire) last_grant_reg <= owner_reg;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed testbench for shift_arbiter.
module tb_shift_arbiter;
  import shift_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [1:0]  req0_op;
  logic [31:0] req0_data, rsp0_data;
  logic [4:0]  req0_amt;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [1:0]  req1_op;
  logic [31:0] req1_data, rsp1_data;
  logic [4:0]  req1_amt;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  shift_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .busy       (busy)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_op = 2'b00; req0_data = '0; req0_amt = '0;
    req1_valid = 1'b0; req1_op = 2'b00; req1_data = '0; req1_amt = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
  endtask

  task automatic drive_req(input int port, input logic [1:0] op,
                           input logic [31:0] data, input logic [4:0] amt);
    if (port == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_data = data; req0_amt = amt;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_data = data; req1_amt = amt;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    cyc();
    cyc();
    tests_run++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b%b required 00", req0_ready, req1_ready);
    end
    tests_run++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid_busy: got rsp0=%b rsp1=%b busy=%b required 0 0 0",
               rsp0_valid, rsp1_valid, busy);
    end
    tests_run++;
    if (rsp0_data !== 32'h0 || rsp1_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h %h required 0 0", rsp0_data, rsp1_data);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_first_tie: got ready0=%b ready1=%b required 1 0",
               req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();
    $display("[TB] reset: done");
  endtask

  // One full request/response on a single port, checking latency and data.
  task automatic test_single_op(input int port, input logic [1:0] op,
                                input logic [31:0] data, input logic [4:0] amt,
                                input logic [31:0] expected, input string name);
    logic my_ready, other_ready, my_valid, other_valid;
    logic [31:0] my_data, other_data;
    drive_req(port, op, data, amt);
    #1;
    my_ready    = (port == 0) ? req0_ready : req1_ready;
    other_ready = (port == 0) ? req1_ready : req0_ready;
    tests_run++;
    if (my_ready !== 1'b1 || other_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_ready: got own=%b other=%b required 1 0", name, my_ready, other_ready);
    end
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_shift: got busy=%b rsp0=%b rsp1=%b required 1 0 0",
               name, busy, rsp0_valid, rsp1_valid);
    end
    cyc();
    my_valid    = (port == 0) ? rsp0_valid : rsp1_valid;
    other_valid = (port == 0) ? rsp1_valid : rsp0_valid;
    my_data     = (port == 0) ? rsp0_data  : rsp1_data;
    other_data  = (port == 0) ? rsp1_data  : rsp0_data;
    tests_run++;
    if (my_valid !== 1'b1 || other_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_rsp_valid: got own=%b other=%b required 1 0", name, my_valid, other_valid);
    end
    tests_run++;
    if (my_data !== expected || other_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL %s_rsp_data: got own=%h other=%h required %h 0",
               name, my_data, other_data, expected);
    end
    cyc();
    tests_run++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_idle: got busy=%b rsp0=%b rsp1=%b required 0 0 0",
               name, busy, rsp0_valid, rsp1_valid);
    end
    $display("[TB] %s: port %0d op %b data %h amt %0d -> %h", name, port, op, data, amt, my_data);
  endtask

  task automatic test_round_robin();
    time last_rsp_time;
    time this_rsp_time;
    int  exp_port;
    last_rsp_time = 0;
    apply_reset();
    drive_req(0, 2'b00, 32'h0000_0010, 5'd1);   // -> 0x20
    drive_req(1, 2'b01, 32'h0000_0010, 5'd1);   // -> 0x08
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_port = k % 2;
      tests_run++;
      if (req0_ready !== (exp_port == 0) || req1_ready !== (exp_port == 1)) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: got ready0=%b ready1=%b required port %0d",
                 k, req0_ready, req1_ready, exp_port);
      end
      cyc();
      tests_run++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL rr_shift_ready%0d: got %b%b required 00", k, req0_ready, req1_ready);
      end
      cyc();
      this_rsp_time = $time;
      tests_run++;
      if (exp_port == 0) begin
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_data !== 32'h0000_0020) begin
          tests_failed++;
          $display("FAIL rr_rsp%0d: got v0=%b v1=%b d0=%h required 1 0 00000020",
                   k, rsp0_valid, rsp1_valid, rsp0_data);
        end
      end else begin
        if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_data !== 32'h0000_0008) begin
          tests_failed++;
          $display("FAIL rr_rsp%0d: got v0=%b v1=%b d1=%h required 0 1 00000008",
                   k, rsp0_valid, rsp1_valid, rsp1_data);
        end
      end
      if (k > 0) begin
        tests_run++;
        if (this_rsp_time - last_rsp_time != 30) begin
          tests_failed++;
          $display("FAIL rr_interval%0d: got %0t required 30", k, this_rsp_time - last_rsp_time);
        end
      end
      $display("[TB] round_robin: transaction %0d served port %0d", k, exp_port);
      last_rsp_time = this_rsp_time;
      cyc();
      if (k == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    rsp0_ready = 1'b0;
    drive_req(0, 2'b10, 32'hF000_0000, 5'd4);   // sra -> 0xFF00_0000
    cyc();
    req0_valid = 1'b0;
    drive_req(1, 2'b00, 32'h0000_0003, 5'd2);   // sll -> 0x0000_000C
    #1;
    tests_run++;
    if (req1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_shift_ready1: got %b required 0", req1_ready);
    end
    cyc();
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (rsp0_valid !== 1'b1 || rsp0_data !== 32'hFF00_0000) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: got v=%b d=%h required 1 ff000000", i, rsp0_valid, rsp0_data);
      end
      tests_run++;
      if (busy !== 1'b1 || req1_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_block%0d: got busy=%b ready1=%b required 1 0", i, busy, req1_ready);
      end
      if (i == 9) rsp0_ready = 1'b1;
      cyc();
    end
    tests_run++;
    if (busy !== 1'b0 || req1_ready !== 1'b1 || rsp0_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: got busy=%b ready1=%b rsp0=%b required 0 1 0",
               busy, req1_ready, rsp0_valid);
    end
    cyc();
    req1_valid = 1'b0;
    cyc();
    tests_run++;
    if (rsp1_valid !== 1'b1 || rsp1_data !== 32'h0000_000C || rsp0_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_req1_rsp: got v1=%b d1=%h v0=%b required 1 0000000c 0",
               rsp1_valid, rsp1_data, rsp0_valid);
    end
    cyc();
    $display("[TB] backpressure: held 10 cycles, then req1 served");
  endtask

  task automatic test_reset_mid_op();
    // Complete a port-0 op so the next tie would favour port 1 without reset.
    apply_reset();
    drive_req(0, 2'b00, 32'h0000_0001, 5'd1);
    cyc();
    req0_valid = 1'b0;
    cyc();
    cyc();
    // Reset during SHIFT.
    drive_req(0, 2'b00, 32'h0000_0001, 5'd4);
    cyc();
    req0_valid = 1'b0;
    reset = 1'b1;
    req1_valid = 1'b1;
    cyc();
    tests_run++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 ||
        req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp0_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_shift: got busy=%b v0=%b v1=%b r0=%b r1=%b d0=%h required all 0",
               busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready, rsp0_data);
    end
    reset = 1'b0;
    req1_valid = 1'b0;
    cyc();
    cyc();
    tests_run++;
    if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_shift_norsp: got v0=%b busy=%b required 0 0", rsp0_valid, busy);
    end
    $display("[TB] reset_mid_op: reset during SHIFT");
    // Complete a port-0 op again, then reset during RESP.
    drive_req(0, 2'b00, 32'h0000_0001, 5'd1);
    cyc();
    req0_valid = 1'b0;
    cyc();
    cyc();
    rsp0_ready = 1'b0;
    drive_req(0, 2'b01, 32'h8000_0000, 5'd3);
    cyc();
    req0_valid = 1'b0;
    cyc();
    tests_run++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h1000_0000) begin
      tests_failed++;
      $display("FAIL rst_resp_pre: got v0=%b d0=%h required 1 10000000", rsp0_valid, rsp0_data);
    end
    reset = 1'b1;
    cyc();
    tests_run++;
    if (rsp0_valid !== 1'b0 || rsp0_data !== 32'h0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_resp: got v0=%b d0=%h busy=%b required 0 0 0", rsp0_valid, rsp0_data, busy);
    end
    reset = 1'b0;
    rsp0_ready = 1'b1;
    drive_req(0, 2'b00, 32'h0, 5'd0);
    drive_req(1, 2'b00, 32'h0, 5'd0);
    #1;
    tests_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_tie: got ready0=%b ready1=%b required 1 0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();
    $display("[TB] reset_mid_op: reset during RESP, tie to port 0");
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_op(0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, "sll_p0");
    test_single_op(1, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, "sra_p1");
    test_single_op(1, 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, "srl_p1");
    test_single_op(0, 2'b10, 32'h4000_0000, 5'd8,  32'h0040_0000, "sra_pos");
    test_single_op(0, 2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "amt0");
    test_single_op(1, 2'b11, 32'h1234_5678, 5'd7,  32'h1234_5678, "pass");
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
